// File: rtl/ex.sv
// Execute stage of the RV32I core: single-cycle ALU ops plus an iterative
// one-bit-per-cycle shifter, with valid/ready handshakes on both sides.
module ex (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  rtlop_i,
    input  logic [2:0]  rtltype_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    input  logic [4:0]  gprs_waddr_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] wdata_o,
    output logic [4:0]  gprs_waddr_o,
    output logic [31:0] pc_o,
    output logic        error_o
);
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SHR  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_SAR  = 4'b1101;
    localparam logic [2:0] ARICH   = 3'b000;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] pc_q, pc_d;
    logic        err_q, err_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] sh_q, sh_d;
    logic [3:0]  op_q, op_d;
    logic [4:0]  swaddr_q, swaddr_d;
    logic [31:0] spc_q, spc_d;

    logic accept, illegal, shift_in;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
            OP_SHR, OP_OR, OP_AND, OP_SAR: op_legal = 1'b1;
            default:                       op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic is_shift(input logic [3:0] op);
        is_shift = (op == OP_SLL) || (op == OP_SHR) || (op == OP_SAR);
    endfunction

    function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        logic signed [31:0] a_s, b_s;
        a_s = a;
        b_s = b;
        case (op)
            OP_ADD:  alu = a + b;
            OP_SLT:  alu = {31'd0, a_s < b_s};
            OP_SLTU: alu = {31'd0, a < b};
            OP_XOR:  alu = a ^ b;
            OP_OR:   alu = a | b;
            OP_AND:  alu = a & b;
            default: alu = 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] shift_step(input logic [3:0] op, input logic [31:0] v);
        case (op)
            OP_SLL:  shift_step = {v[30:0], 1'b0};
            OP_SAR:  shift_step = {v[31], v[31:1]};
            default: shift_step = {1'b0, v[31:1]};
        endcase
    endfunction

    assign accept   = in_valid && in_ready;
    assign illegal  = (rtltype_i != ARICH) || !op_legal(rtlop_i);
    assign shift_in = !illegal && is_shift(rtlop_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept && shift_in) state_d = SHIFT;
                SHIFT:   if (cnt_q == 5'd0)      state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Flush blocks acceptance so a squashed op can never enter the stage.
    always_comb begin
        in_ready = !flush && (state_q == IDLE) && (!out_valid_q || out_ready);
    end

    always_comb begin
        out_valid_d = out_valid_q;
        wdata_d     = wdata_q;
        waddr_d     = waddr_q;
        pc_d        = pc_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        op_d        = op_q;
        swaddr_d    = swaddr_q;
        spc_d       = spc_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else begin
            if (out_ready) out_valid_d = 1'b0;
            if (accept) begin
                if (illegal) begin
                    out_valid_d = 1'b1;
                    wdata_d     = 32'd0;
                    waddr_d     = 5'd0;
                    pc_d        = pc_i;
                    err_d       = 1'b1;
                end else if (shift_in) begin
                    sh_d     = src1_i;
                    cnt_d    = src2_i[4:0];
                    op_d     = rtlop_i;
                    swaddr_d = gprs_waddr_i;
                    spc_d    = pc_i;
                end else begin
                    out_valid_d = 1'b1;
                    wdata_d     = (gprs_waddr_i == 5'd0) ? 32'd0 : alu(rtlop_i, src1_i, src2_i);
                    waddr_d     = gprs_waddr_i;
                    pc_d        = pc_i;
                    err_d       = 1'b0;
                end
            end
            // Output register is guaranteed free here: acceptance required it.
            if (state_q == SHIFT) begin
                if (cnt_q != 5'd0) begin
                    sh_d  = shift_step(op_q, sh_q);
                    cnt_d = cnt_q - 5'd1;
                end else begin
                    out_valid_d = 1'b1;
                    wdata_d     = (swaddr_q == 5'd0) ? 32'd0 : sh_q;
                    waddr_d     = swaddr_q;
                    pc_d        = spc_q;
                    err_d       = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            wdata_q     <= 32'd0;
            waddr_q     <= 5'd0;
            pc_q        <= 32'd0;
            err_q       <= 1'b0;
            cnt_q       <= 5'd0;
            sh_q        <= 32'd0;
            op_q        <= 4'd0;
            swaddr_q    <= 5'd0;
            spc_q       <= 32'd0;
        end else begin
            out_valid_q <= out_valid_d;
            wdata_q     <= wdata_d;
            waddr_q     <= waddr_d;
            pc_q        <= pc_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            op_q        <= op_d;
            swaddr_q    <= swaddr_d;
            spc_q       <= spc_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign wdata_o      = wdata_q;
    assign gprs_waddr_o = waddr_q;
    assign pc_o         = pc_q;
    assign error_o      = err_q;
endmodule

// File: doc/ex.md
# ex

Execute stage of the in-order RV32I core. It accepts one decoded arithmetic micro-op per handshake from the ID_EX register: op, type, PC, two 32-bit operands and destination register. It computes the result and presents it, with the destination register and an error flag, to the writeback side through a second valid/ready handshake. Add, compare and logic ops complete in one cycle. Shifts run on an iterative one-bit-per-cycle shifter, so the stage back-pressures ID while a shift is in progress.

## Interface
Parameters:
- none (widths fixed: data 32, register address 5, rtlop 4, rtltype 3)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous and active-high
- flush  input  1  synchronous pipeline flush
- in_valid  input  1  ID_EX holds a micro-op
- in_ready  output  1  stage can accept this cycle
- rtlop_i  input  4  ADD=0000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SHR=0101, OR=0110, AND=0111, SAR=1101
- rtltype_i  input  3  ARICH=000; any other value is illegal
- pc_i  input  32  instruction PC, passed through
- src1_i  input  32  operand 1
- src2_i  input  32  operand 2; shift amount is src2_i[4:0]
- gprs_waddr_i  input  5  destination register
- out_valid  output  1  result held for writeback
- out_ready  input  1  writeback consumes result
- wdata_o  output  32  result
- gprs_waddr_o  output  5  destination register
- pc_o  output  32  PC of the result
- error_o  output  1  illegal op/type

## Operation
- FSM has two states: IDLE and SHIFT.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This is combinational, with no dependence on in_valid.
- Accept happens when in_valid && in_ready at a rising edge.
- Non-shift legal op in IDLE: the result is registered into the output at the accept edge, and out_valid is set.
  - ADD: src1+src2, modulo 2^32.
  - SLT: signed compare, result 1 or 0.
  - SLTU: unsigned compare, result 1 or 0.
  - XOR, OR, AND: bitwise.
- Shift op (SLL, SHR, SAR) in IDLE: the accept edge does three things:
  - loads the shift register with src1;
  - loads the 5-bit count with src2[4:0];
  - latches op, waddr and pc, then moves to SHIFT.
- Each SHIFT cycle:
  - If count!=0: shift one bit (SLL: left, zero fill; SHR: right, zero fill; SAR: right, sign fill) and decrement count.
  - If count==0: write the shift register to the output, set out_valid, return to IDLE.
- Illegal input completes like a single-cycle op: wdata_o=0, gprs_waddr_o=0, error_o=1, pc_o=pc_i. An input is illegal if either:
  - rtltype_i != ARICH, or
  - rtlop_i is not in the listed encodings.
- If the destination is x0 (waddr==0), wdata_o is forced to 0.
- Output holding: while out_valid && !out_ready, every output stays stable.
- out_valid clears on out_ready unless a new result is written in the same edge.
- At shift completion the output register is always free, because acceptance already required it.
- flush (synchronous) overrides everything else at the edge:
  - state←IDLE, out_valid←0;
  - count and shift register contents become don't-care;
  - any in_valid in the same cycle is not accepted (in_ready is forced 0 while flush is high).

## Timing
- Reset values:
  - state=IDLE, out_valid=0, wdata_o=0, gprs_waddr_o=0, pc_o=0, error_o=0, count=0.
  - in_ready=1 after reset deasserts.
- Non-shift or illegal op accepted at edge N: out_valid is visible in the cycle after N (latency 1).
- Shift by k (0..31) accepted at edge N: the stage is in SHIFT for k+1 cycles. out_valid rises at edge N+1+k. in_ready=0 from edge N until the return to IDLE.
- Back-to-back single-cycle ops with out_ready=1 sustain one op per cycle.
- Reset asserted mid-shift aborts the op immediately (asynchronous). No output is produced.
- Simultaneous out_ready and a new accept: the old result retires and the new result is loaded at the same edge, so out_valid stays 1.

## Test plan
- ADD src1=0xFFFFFFFF, src2=1, waddr=5, out_ready=1 → next cycle: out_valid=1, wdata_o=0, gprs_waddr_o=5, error_o=0.
- SLT with src1=0x80000000, src2=1 → wdata_o=1. SLTU with the same operands → wdata_o=0.
- SAR src1=0x80000010, src2=4, accept at edge N → in_ready=0 for 5 cycles. out_valid rises at N+5 with wdata_o=0xF8000001. Shift amount 0 → out_valid rises at N+1 with the unchanged value.
- Back-pressure: out_ready=0 after an ADD result → in_ready=0 and outputs stable for 3 cycles. Raising out_ready together with a new in_valid XOR → XOR result appears on the next cycle.
- Illegal inputs: rtltype_i=001, or rtlop_i=1000 → error_o=1, wdata_o=0, gprs_waddr_o=0, pc_o equals pc_i. Destination waddr=0 with ADD 3+4 → wdata_o=0.
- Disruptions mid-operation:
  - flush during SHIFT (k=20) → next cycle state IDLE, out_valid=0, in_ready=1.
  - rst asserted mid-shift → all outputs at reset values immediately, no output produced.
